// File: rtl/hack_mem_pkg.sv
// Shared types and default geometry for the Hack data-memory map.
package hack_mem_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 15;
    localparam int DEF_RAM_WORDS    = 16384;
    localparam int DEF_SCREEN_BASE  = 16384;
    localparam int DEF_SCREEN_WORDS = 8192;
    localparam int DEF_KBD_ADDR     = 24576;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_NONE
    } region_e;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

endpackage

// File: rtl/hack_mem_map_if.sv
// CPU data port and video read port of the Hack memory map.
interface hack_mem_map_if #(
    parameter int DATA_W  = 16,
    parameter int VADDR_W = 13
);
    logic [15:0]         address;
    logic [DATA_W-1:0]   dataW;
    logic                load;
    logic [DATA_W-1:0]   dataR;
    logic [VADDR_W-1:0]  vaddr;
    logic [DATA_W-1:0]   vdata;

    modport master (
        output address, dataW, load, vaddr,
        input  dataR, vdata
    );

    modport slave (
        input  address, dataW, load, vaddr,
        output dataR, vdata
    );
endinterface

// File: rtl/hack_dpram.sv
// One write port, two registered read ports; storage is not reset.
// Reads return the word's value before a same-edge write (read-first).
module hack_dpram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 24576,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end
endmodule

// File: rtl/hack_mem_map.sv
// Hack data-memory map: zero-fill after reset, region decode, keyboard register, video read port.
// Optional macro WR_BYPASS_EN makes the CPU port write-first; default build is read-first.
module hack_mem_map
    import hack_mem_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RAM_WORDS    = DEF_RAM_WORDS,
    parameter int SCREEN_BASE  = DEF_SCREEN_BASE,
    parameter int SCREEN_WORDS = DEF_SCREEN_WORDS,
    parameter int KBD_ADDR     = DEF_KBD_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    hack_mem_map_if.slave     bus,
    input  logic [DATA_W-1:0] kbd_code,
    output logic              busy
);
    localparam int DEPTH = RAM_WORDS + SCREEN_WORDS;
    localparam int IDX_W = $clog2(DEPTH);

    state_e            state;
    logic [IDX_W-1:0]  fill_cnt;
    logic [DATA_W-1:0] kbd_q;
    logic              rd_mem_q;
    logic [DATA_W-1:0] rd_misc_q;
    logic              vid_q;

    logic [ADDR_W-1:0] a;
    logic              addr_unused;
    region_e           region;
    logic [IDX_W-1:0]  cpu_idx;
    logic [IDX_W-1:0]  vid_idx;
    logic              cpu_wr;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata_a;
    logic [DATA_W-1:0] mem_rdata_b;

    assign a           = bus.address[ADDR_W-1:0];
    assign addr_unused = ^bus.address[15:ADDR_W];

    // Screen words sit directly after RAM in the shared array.
    always_comb begin
        region  = REG_NONE;
        cpu_idx = '0;
        if (int'(a) < RAM_WORDS) begin
            region  = REG_RAM;
            cpu_idx = IDX_W'(int'(a));
        end else if (int'(a) >= SCREEN_BASE && int'(a) < SCREEN_BASE + SCREEN_WORDS) begin
            region  = REG_SCREEN;
            cpu_idx = IDX_W'(int'(a) - SCREEN_BASE + RAM_WORDS);
        end else if (int'(a) == KBD_ADDR) begin
            region  = REG_KBD;
        end
    end

    assign vid_idx   = IDX_W'(RAM_WORDS + int'(bus.vaddr));
    assign cpu_wr    = (state == ST_RUN) && bus.load &&
                       (region == REG_RAM || region == REG_SCREEN);
    assign mem_we    = (state == ST_CLEAR) || cpu_wr;
    assign mem_waddr = (state == ST_CLEAR) ? fill_cnt : cpu_idx;
    assign mem_wdata = (state == ST_CLEAR) ? '0 : bus.dataW;

    hack_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (cpu_idx),
        .rdata_a (mem_rdata_a),
        .raddr_b (vid_idx),
        .rdata_b (mem_rdata_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_CLEAR;
            fill_cnt  <= '0;
            busy      <= 1'b1;
            kbd_q     <= '0;
            rd_mem_q  <= 1'b0;
            rd_misc_q <= '0;
            vid_q     <= 1'b0;
        end else begin
            kbd_q <= kbd_code;
            case (state)
                ST_CLEAR: begin
                    rd_mem_q  <= 1'b0;
                    rd_misc_q <= '0;
                    vid_q     <= 1'b0;
                    if (fill_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rd_mem_q  <= (region == REG_RAM) || (region == REG_SCREEN);
                    rd_misc_q <= (region == REG_KBD) ? kbd_q : '0;
                    vid_q     <= 1'b1;
                end
            endcase
        end
    end

`ifdef WR_BYPASS_EN
    logic              byp_q;
    logic [DATA_W-1:0] byp_dat_q;

    // The CPU reads and writes through one address, so any storage write is a same-word hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byp_q     <= 1'b0;
            byp_dat_q <= '0;
        end else begin
            byp_q     <= cpu_wr;
            byp_dat_q <= bus.dataW;
        end
    end

    assign bus.dataR = byp_q ? byp_dat_q : (rd_mem_q ? mem_rdata_a : rd_misc_q);
`else
    assign bus.dataR = rd_mem_q ? mem_rdata_a : rd_misc_q;
`endif

    assign bus.vdata = vid_q ? mem_rdata_b : '0;

endmodule

// File: tb/tb_hack_mem_map.sv
// Randomised and directed bench for hack_mem_map against an address-level reference model.
module tb_hack_mem_map;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] kbd_code;
    logic        busy;

    always #5 clk = ~clk;

    hack_mem_map_if #(.DATA_W(16), .VADDR_W(13)) bus ();

    hack_mem_map dut (
        .clk      (clk),
        .reset    (rst),
        .bus      (bus),
        .kbd_code (kbd_code),
        .busy     (busy)
    );

    logic [15:0] ref_mem [0:32767];
    logic [15:0] kbd_last;
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Addresses below 0x6000 are RAM then screen, contiguous; 0x6000 is the keyboard.
    function automatic logic [15:0] ref_read(input logic [14:0] a);
        if (a < 15'h6000) return ref_mem[a];
        if (a == 15'h6000) return kbd_last;
        return 16'h0;
    endfunction

    task automatic cyc(input logic [15:0] addr, input logic [15:0] din, input logic ld,
                       input logic [12:0] va, input logic [15:0] kbd);
        logic [14:0] a;
        logic [14:0] vi;
        logic [15:0] exp_r;
        logic [15:0] exp_v;
        a  = addr[14:0];
        vi = 15'h4000 + {2'b00, va};
        bus.address = addr;
        bus.dataW   = din;
        bus.load    = ld;
        bus.vaddr   = va;
        kbd_code    = kbd;
        exp_r = ref_read(a);
        exp_v = ref_mem[vi];
`ifdef WR_BYPASS_EN
        if (ld && a < 15'h6000) exp_r = din;
`endif
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("dataR@%h", addr), {16'h0, bus.dataR}, {16'h0, exp_r});
        chk($sformatf("vdata@%h", va), {16'h0, bus.vdata}, {16'h0, exp_v});
        if (ld && a < 15'h6000) ref_mem[a] = din;
        kbd_last = kbd;
    endtask

    initial begin
        int          cnt;
        logic [15:0] addr;
        logic [12:0] va;

        rst         = 1'b1;
        bus.address = 16'h0;
        bus.dataW   = 16'h0;
        bus.load    = 1'b0;
        bus.vaddr   = 13'h0;
        kbd_code    = 16'h0;
        kbd_last    = 16'h0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 16'h0;

        @(negedge clk);
        @(negedge clk);
        chk("busy_in_reset", {31'h0, busy}, 32'd1);
        chk("dataR_in_reset", {16'h0, bus.dataR}, 32'h0);
        chk("vdata_in_reset", {16'h0, bus.vdata}, 32'h0);

        // CPU writes during the fill must be ignored.
        rst         = 1'b0;
        bus.address = 16'h0005;
        bus.dataW   = 16'hABCD;
        bus.load    = 1'b1;
        for (int i = 0; i < 100; i++) @(negedge clk);
        chk("busy_fill100", {31'h0, busy}, 32'd1);
        chk("dataR_fill", {16'h0, bus.dataR}, 32'h0);
        chk("vdata_fill", {16'h0, bus.vdata}, 32'h0);

        rst = 1'b1;
        #1;
        chk("busy_rereset", {31'h0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 30000) begin
            cnt++;
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("busy_cycles", cnt, 32'd24576);

        cyc(16'h0000, 16'h0, 1'b0, 13'h0, 16'h0);
        cyc(16'h3FFF, 16'h0, 1'b0, 13'h0, 16'h0);
        cyc(16'h4000, 16'h0, 1'b0, 13'h0, 16'h0);
        cyc(16'h5FFF, 16'h0, 1'b0, 13'h0, 16'h0);
        cyc(16'h0005, 16'h0, 1'b0, 13'h0, 16'h0);
        chk("ram5_zero", {16'h0, bus.dataR}, 32'h0);

        cyc(16'h0010, 16'h1234, 1'b1, 13'h0, 16'h0);
        cyc(16'h0010, 16'h0, 1'b0, 13'h0, 16'h0);
        chk("rd_0010", {16'h0, bus.dataR}, 32'h1234);
        cyc(16'h3FFF, 16'hBEEF, 1'b1, 13'h0, 16'h0);
        cyc(16'h3FFF, 16'h0, 1'b0, 13'h0, 16'h0);
        chk("rd_3fff", {16'h0, bus.dataR}, 32'hBEEF);

        cyc(16'h4000, 16'hFFFF, 1'b1, 13'h0000, 16'h0);
        cyc(16'h5FFF, 16'h8001, 1'b1, 13'h0000, 16'h0);
        chk("vid_0000", {16'h0, bus.vdata}, 32'hFFFF);
        cyc(16'h0000, 16'h0, 1'b0, 13'h1FFF, 16'h0);
        chk("vid_1fff", {16'h0, bus.vdata}, 32'h8001);

        cyc(16'h0000, 16'h0, 1'b0, 13'h0, 16'h0041);
        cyc(16'h6000, 16'h0, 1'b0, 13'h0, 16'h0041);
        chk("kbd_read", {16'h0, bus.dataR}, 32'h0041);
        cyc(16'h6000, 16'h7777, 1'b1, 13'h0, 16'h0041);
        cyc(16'h6001, 16'h7777, 1'b1, 13'h0, 16'h0041);
        cyc(16'h6000, 16'h0, 1'b0, 13'h0, 16'h0041);
        chk("kbd_after_wr", {16'h0, bus.dataR}, 32'h0041);
        cyc(16'h6001, 16'h0, 1'b0, 13'h0, 16'h0041);
        chk("illegal_rd", {16'h0, bus.dataR}, 32'h0);

        cyc(16'h0008, 16'h1111, 1'b1, 13'h0, 16'h0);
        cyc(16'h0008, 16'h2222, 1'b1, 13'h0, 16'h0);
`ifdef WR_BYPASS_EN
        chk("rdw_same", {16'h0, bus.dataR}, 32'h2222);
`else
        chk("rdw_same", {16'h0, bus.dataR}, 32'h1111);
`endif
        cyc(16'h0008, 16'h0, 1'b0, 13'h0, 16'h0);
        chk("rdw_after", {16'h0, bus.dataR}, 32'h2222);

        // Concentrated address pools so random reads frequently hit earlier writes.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 5))
                0: addr = 16'($urandom_range(0, 15));
                1: addr = 16'h3FF0 + 16'($urandom_range(0, 15));
                2: addr = ($urandom_range(0, 1) != 0) ? 16'h4000 + 16'($urandom_range(0, 15))
                                                      : 16'h5FF0 + 16'($urandom_range(0, 15));
                3: addr = 16'h6000;
                4: addr = 16'h6001 + 16'($urandom_range(0, 16'h1FFE));
                default: addr = 16'h8000 | 16'($urandom_range(0, 15));
            endcase
            va = ($urandom_range(0, 1) != 0) ? 13'($urandom_range(0, 15))
                                             : 13'h1FF0 + 13'($urandom_range(0, 15));
            cyc(addr, 16'($urandom()), 1'($urandom_range(0, 1)), va, 16'($urandom()));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
